// File: rtl/bcd_conv_seq.sv
// ============================================================================
// Module   : bcd_conv_seq
// Brief    : Sequential 16-bit binary to 5-digit packed BCD converter using
//            iterative shift-add-3 (double dabble), one bit per clock.
//            Reports the significant-digit count for leading-zero blanking.
//            Optional macro BCD_PENDING_BUF_EN adds a 1-entry pending
//            register that holds one sample arriving during a conversion
//            (latest wins on overflow). Without it, every sample arriving
//            while busy is dropped.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_conv_seq #(
    parameter int W_IN  = 16,
    parameter int N_DIG = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_2_valid,
    input  logic [W_IN-1:0]      data_2,
    output logic                 busy,
    output logic [4*N_DIG-1:0]   bcd,
    output logic                 bcd_valid,
    output logic [2:0]           ndig,
    output logic                 drop
);

    // Working register: BCD digits on top, binary word underneath.
    localparam int                c_W_BCD  = 4 * N_DIG;
    localparam int                c_W_WORK = c_W_BCD + W_IN;
    localparam int                c_CNT_W  = $clog2(W_IN);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(W_IN - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                 r_state;
    logic [c_W_WORK-1:0]    r_work;
    logic [c_CNT_W-1:0]     r_cnt;

    logic [c_W_WORK-1:0]    w_adj;
    logic [c_W_WORK-1:0]    w_shift;
    logic [c_W_BCD-1:0]     w_result;
    logic [2:0]             w_ndig;
    logic                   w_load;
    logic [W_IN-1:0]        w_load_data;

`ifdef BCD_PENDING_BUF_EN
    logic                   r_pend_full;
    logic [W_IN-1:0]        r_pend_data;
`endif

    // One double-dabble step: add 3 to every digit >= 5, then shift left.
    always_comb begin
        w_adj = r_work;
        for (int d = 0; d < N_DIG; d++) begin
            if (r_work[W_IN + 4*d +: 4] >= 4'd5) begin
                w_adj[W_IN + 4*d +: 4] = r_work[W_IN + 4*d +: 4] + 4'd3;
            end
        end
        w_shift  = {w_adj[c_W_WORK-2:0], 1'b0};
        w_result = w_shift[c_W_WORK-1:W_IN];
    end

    // Significant digits of the result about to be published (0 counts as 1).
    always_comb begin
        w_ndig = 3'd1;
        for (int d = 0; d < N_DIG; d++) begin
            if (w_result[4*d +: 4] != 4'd0) begin
                w_ndig = 3'(d + 1);
            end
        end
    end

    // Select what IDLE loads: the pending entry has priority over new input.
    always_comb begin
        w_load      = data_2_valid;
        w_load_data = data_2;
`ifdef BCD_PENDING_BUF_EN
        if (r_pend_full) begin
            w_load      = 1'b1;
            w_load_data = r_pend_data;
        end
`endif
    end

    // Control FSM, working register, pending entry and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_work      <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            bcd         <= '0;
            bcd_valid   <= 1'b0;
            ndig        <= 3'd1;
            drop        <= 1'b0;
`ifdef BCD_PENDING_BUF_EN
            r_pend_full <= 1'b0;
            r_pend_data <= '0;
`endif
        end else begin
            bcd_valid <= 1'b0;
            drop      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_work  <= {{c_W_BCD{1'b0}}, w_load_data};
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end
`ifdef BCD_PENDING_BUF_EN
                    // Entry was just consumed; a simultaneous sample refills it.
                    if (r_pend_full) begin
                        r_pend_full <= data_2_valid;
                        if (data_2_valid) begin
                            r_pend_data <= data_2;
                        end
                    end
`endif
                end
                S_SHIFT: begin
                    r_work <= w_shift;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        bcd       <= w_result;
                        ndig      <= w_ndig;
                        bcd_valid <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
`ifdef BCD_PENDING_BUF_EN
                    // Latest sample wins; overwriting a held one is a drop.
                    if (data_2_valid) begin
                        if (r_pend_full) begin
                            drop <= 1'b1;
                        end
                        r_pend_data <= data_2;
                        r_pend_full <= 1'b1;
                    end
`else
                    if (data_2_valid) begin
                        drop <= 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv_seq.sv
// ============================================================================
// Module   : tb_bcd_conv_seq
// Brief    : Directed self-checking bench for bcd_conv_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_conv_seq;

    logic        clk;
    logic        rst;
    logic        data_2_valid;
    logic [15:0] data_2;
    logic        busy;
    logic [19:0] bcd;
    logic        bcd_valid;
    logic [2:0]  ndig;
    logic        drop;

    int checks   = 0;
    int failures = 0;

    bcd_conv_seq #(.W_IN(16), .N_DIG(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_2_valid (data_2_valid),
        .data_2       (data_2),
        .busy         (busy),
        .bcd          (bcd),
        .bcd_valid    (bcd_valid),
        .ndig         (ndig),
        .drop         (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference conversion by repeated division (independent of double dabble).
    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [2:0] ref_ndig(input int v);
        if (v >= 10000) return 3'd5;
        if (v >= 1000)  return 3'd4;
        if (v >= 100)   return 3'd3;
        if (v >= 10)    return 3'd2;
        return 3'd1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept v at edge N, watch edges N+1..N+16, leave just after N+16.
    task automatic run_conv(input logic [15:0] v, input logic [19:0] eb,
                            input logic [2:0] en, input string name);
        logic [19:0] pb;
        logic [2:0]  pn;
        int early;
        int drops;
        int moves;
        pb = bcd; pn = ndig; early = 0; drops = 0; moves = 0;
        data_2 = v; data_2_valid = 1'b1;
        tick();
        data_2_valid = 1'b0; data_2 = 16'h0;
        checks++;
        if (busy !== 1'b1 || bcd_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_accept: busy=%b bcd_valid=%b, expected busy=1 bcd_valid=0", name, busy, bcd_valid);
        end
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (bcd_valid !== 1'b0 || busy !== 1'b1) early++;
            if (drop !== 1'b0) drops++;
            if (bcd !== pb || ndig !== pn) moves++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL %s_timing: %0d bad busy/bcd_valid cycles during shift, expected 0", name, early);
        end
        checks++;
        if (moves != 0 || drops != 0) begin
            failures++;
            $display("FAIL %s_stable: %0d output changes, %0d drops during shift, expected 0 and 0", name, moves, drops);
        end
        tick();
        checks++;
        if (bcd_valid !== 1'b1 || busy !== 1'b0 || bcd !== eb || ndig !== en) begin
            failures++;
            $display("FAIL %s_result: bcd_valid=%b busy=%b bcd=%h ndig=%0d, expected 1 0 %h %0d",
                     name, bcd_valid, busy, bcd, ndig, eb, en);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; data_2_valid = 1'b0; data_2 = 16'h0;
        tick(); tick(); tick();
        rst = 1'b0;
        tick(); tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (bcd !== 20'h00000) begin failures++; $display("FAIL reset_bcd: got %h expected 00000", bcd); end
        checks++;
        if (ndig !== 3'd1) begin failures++; $display("FAIL reset_ndig: got %0d expected 1", ndig); end
        checks++;
        if (bcd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bcd_valid); end
        checks++;
        if (drop !== 1'b0) begin failures++; $display("FAIL reset_drop: got %b expected 0", drop); end
    endtask

    task automatic test_single();
        run_conv(16'd1234, 20'h01234, 3'd4, "conv1234");
        tick();
        checks++;
        if (bcd_valid !== 1'b0 || bcd !== 20'h01234) begin
            failures++;
            $display("FAIL pulse_width: bcd_valid=%b bcd=%h, expected 0 01234", bcd_valid, bcd);
        end
        run_conv(16'd0, 20'h00000, 3'd1, "conv0");
        tick();
    endtask

    task automatic test_extremes();
        run_conv(16'd65535, 20'h65535, 3'd5, "conv65535");
        run_conv(16'd9,     20'h00009, 3'd1, "conv9");
        run_conv(16'd10000, 20'h10000, 3'd5, "conv10000");
        tick();
    endtask

    task automatic test_collision();
        int ndrop;
        int dropbad;
        int vcount;
        logic exp_drop;
        ndrop = 0; dropbad = 0; vcount = 0;
        data_2 = 16'd100; data_2_valid = 1'b1;
        tick();
        data_2_valid = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            if (e == 5) begin
                data_2 = 16'd200; data_2_valid = 1'b1;
            end else if (e == 8) begin
                data_2 = 16'd300; data_2_valid = 1'b1;
            end
            tick();
            data_2_valid = 1'b0;
`ifdef BCD_PENDING_BUF_EN
            exp_drop = (e == 8);
`else
            exp_drop = (e == 5) || (e == 8);
`endif
            if (drop !== exp_drop) dropbad++;
            if (drop === 1'b1) ndrop++;
        end
        checks++;
        if (bcd_valid !== 1'b1 || bcd !== 20'h00100) begin
            failures++;
            $display("FAIL coll_first: bcd_valid=%b bcd=%h, expected 1 00100", bcd_valid, bcd);
        end
        checks++;
`ifdef BCD_PENDING_BUF_EN
        if (dropbad != 0 || ndrop != 1) begin
            failures++;
            $display("FAIL coll_drop: %0d drops (%0d misplaced), expected 1", ndrop, dropbad);
        end
        for (int e = 17; e <= 33; e++) begin
            tick();
            if (e == 17) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL coll_pend_load: busy=%b, expected 1", busy);
                end
            end else if (e < 33) begin
                if (bcd_valid === 1'b1) vcount++;
            end
        end
        checks++;
        if (bcd_valid !== 1'b1 || bcd !== 20'h00300 || ndig !== 3'd3 || vcount != 0) begin
            failures++;
            $display("FAIL coll_pend_result: bcd_valid=%b bcd=%h ndig=%0d early=%0d, expected 1 00300 3 0",
                     bcd_valid, bcd, ndig, vcount);
        end
`else
        if (dropbad != 0 || ndrop != 2) begin
            failures++;
            $display("FAIL coll_drop: %0d drops (%0d misplaced), expected 2", ndrop, dropbad);
        end
        for (int e = 17; e <= 33; e++) begin
            tick();
            if (bcd_valid === 1'b1 || busy === 1'b1) vcount++;
        end
        checks++;
        if (vcount != 0 || bcd !== 20'h00100) begin
            failures++;
            $display("FAIL coll_nothing_more: %0d busy/valid cycles bcd=%h, expected 0 00100", vcount, bcd);
        end
`endif
        tick();
    endtask

    task automatic test_async_reset();
        int bad;
        bad = 0;
        data_2 = 16'd4321; data_2_valid = 1'b1;
        tick();
        data_2_valid = 1'b0;
        for (int k = 1; k <= 7; k++) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || bcd !== 20'h00000 || ndig !== 3'd1 || bcd_valid !== 1'b0 || drop !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: busy=%b bcd=%h ndig=%0d valid=%b drop=%b, expected 0 00000 1 0 0",
                     busy, bcd, ndig, bcd_valid, drop);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (bcd_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL async_abort: %0d busy/valid cycles after abort, expected 0", bad);
        end
        run_conv(16'd42, 20'h00042, 3'd2, "conv42");
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        for (int i = 0; i < 20; i++) begin
            v = 16'($urandom_range(0, 65535));
            run_conv(v, ref_bcd(int'(v)), ref_ndig(int'(v)), "b2b");
        end
        tick();
        checks++;
        if (drop !== 1'b0 || bcd_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: drop=%b valid=%b busy=%b, expected 0 0 0", drop, bcd_valid, busy);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        data_2_valid = 1'b0;
        data_2 = 16'h0;
        test_reset();
        test_single();
        test_extremes();
        test_collision();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
